// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter: FSM state encoding and
// the index-width helper used to size requester indices.
package bram_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot encoder: picks the first set request scanning
// from ptr upward, wrapping modulo NREQ. Purely combinational.
module rr_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port among NREQ requesters with round-robin arbitration,
// optional locked bursts of up to MAX_BURST accesses, and per-requester read return.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 36,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_wd,
  input  logic [DATA_W-1:0]        bram_rd,
  output logic                     dbg_st
);

  // Handshake: req is held until gnt; gnt is the access itself, issued in the
  // same cycle. A read granted in cycle t returns rvalid and rdata in t+1.

  localparam int IDX_W = idx_width(NREQ);

  arb_state_e       st_q, st_d;
  logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic [IDX_W-1:0] pick_idx, win_idx, sel_idx;
  logic [4:0]       cnt_q, cnt_d, cnt_base;
  logic [NREQ-1:0]  rvalid_q, rvalid_d, pick_oh, owner_oh;
  logic             pick_any, burst_hold, win_any;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Winner and RAM port mux. Grants are suppressed while reset is high.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    burst_hold        = (st_q == ARB_BURST) && req[owner_q];
    win_any           = (burst_hold || pick_any) && !reset;
    win_idx           = burst_hold ? owner_q : pick_idx;
    sel_idx           = win_any ? win_idx : '0;
    gnt               = '0;
    if (win_any) gnt = burst_hold ? owner_oh : pick_oh;
    bram_en   = win_any;
    bram_we   = win_any && wr[sel_idx];
    bram_addr = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
    bram_wd   = wdata[int'(sel_idx)*DATA_W +: DATA_W];
  end

  // A newly arbitrated winner starts its burst count from zero, even when it
  // displaced an owner that dropped req.
  always_comb begin
    st_d     = ARB_IDLE;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = '0;
    cnt_base = burst_hold ? cnt_q : '0;
    if (win_any) begin
      ptr_d = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
      if (!last[win_idx] && ((cnt_base + 5'd1) != 5'(MAX_BURST))) begin
        st_d    = ARB_BURST;
        owner_d = win_idx;
        cnt_d   = cnt_base + 5'd1;
      end
    end
    rvalid_d = gnt & ~wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= ARB_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      st_q     <= st_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = bram_rd;
  assign dbg_st = st_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter (NREQ=4, MAX_BURST=4) with a
// write-first RAM model behind the arbitrated port.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int NREQ      = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 36;
  localparam int MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, wr, last;
  logic [ADDR_W-1:0]      addr_a [NREQ];
  logic [DATA_W-1:0]      wdata_a [NREQ];
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]      rdata, bram_wd, bram_rd;
  logic                   bram_en, bram_we, dbg_st;
  logic [ADDR_W-1:0]      bram_addr;
  logic [DATA_W-1:0]      mem [1024];

  int errors = 0;
  int checks = 0;

  assign addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};

  // Clock and reset
  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(rst), .req(req), .wr(wr), .last(last),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wd(bram_wd), .bram_rd(bram_rd), .dbg_st(dbg_st)
  );

  // Write-first RAM, one cycle read latency, no output register
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_wd;
        bram_rd        <= bram_wd;
      end else begin
        bram_rd <= mem[bram_addr];
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
    @(negedge clk);
    req = r; wr = w; last = l;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; wr = '0; last = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_g [5];
    logic [3:0] prev;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev  = '0;
    drive(4'b1111, 4'b0000, 4'b0000);
    drive(4'b1111, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || bram_en !== 1'b0) begin
      errors++; $display("FAIL reset_async gnt/en: got %b/%b expected 0000/0", gnt, bram_en);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin
        errors++; $display("FAIL reset_hold gnt/rvalid: got %b/%b expected 0000/0000", gnt, rvalid);
      end
    end
    @(negedge clk);
    rst = 1'b0; req = 4'b1111; wr = 4'b0000; last = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (gnt !== exp_g[k]) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_g[k]);
      end
      checks++;
      if (rvalid !== prev) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, prev);
      end
      prev = exp_g[k];
      @(negedge clk); #1;
    end
    checks++;
    if (rvalid !== prev) begin
      errors++; $display("FAIL rr_rvalid_last: got %b expected %b", rvalid, prev);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_burst_lock();
    do_reset();
    drive(4'b0100, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL burst_first gnt: got %b expected 0100", gnt);
    end
    for (int k = 0; k < 3; k++) begin
      drive(4'b0101, 4'b0000, 4'b0000);
      checks++;
      if (gnt !== 4'b0100 || dbg_st !== ARB_BURST) begin
        errors++; $display("FAIL burst_hold[%0d] gnt/st: got %b/%b expected 0100/1", k, gnt, dbg_st);
      end
    end
    drive(4'b0101, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL burst_release gnt: got %b expected 0001", gnt);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_early_release();
    do_reset();
    drive(4'b0010, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL early_first gnt: got %b expected 0010", gnt);
    end
    drive(4'b0010, 4'b0000, 4'b0010);
    checks++;
    if (gnt !== 4'b0010 || dbg_st !== ARB_BURST) begin
      errors++; $display("FAIL early_last gnt/st: got %b/%b expected 0010/1", gnt, dbg_st);
    end
    drive(4'b0110, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0100 || dbg_st !== ARB_IDLE) begin
      errors++; $display("FAIL early_next gnt/st: got %b/%b expected 0100/0", gnt, dbg_st);
    end
    do_reset();
    drive(4'b0010, 4'b0000, 4'b0000);
    drive(4'b0010, 4'b0000, 4'b0010);
    drive(4'b0010, 4'b0000, 4'b0010);
    checks++;
    if (gnt !== 4'b0010 || dbg_st !== ARB_IDLE) begin
      errors++; $display("FAIL early_regrant gnt/st: got %b/%b expected 0010/0", gnt, dbg_st);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_write_read();
    do_reset();
    addr_a[3] = 10'h3FF; wdata_a[3] = 36'h9_DEAD_BEEF;
    addr_a[0] = 10'h155; wdata_a[0] = 36'h0_1234_5678;
    drive(4'b1000, 4'b1000, 4'b1000);
    checks++;
    if (gnt !== 4'b1000 || bram_we !== 1'b1 || bram_addr !== 10'h3FF || bram_wd !== 36'h9_DEAD_BEEF) begin
      errors++; $display("FAIL wr_port gnt/we/addr/wd: got %b/%b/%h/%h expected 1000/1/3ff/9deadbeef",
                         gnt, bram_we, bram_addr, bram_wd);
    end
    drive(4'b1000, 4'b0000, 4'b1000);
    checks++;
    if (gnt !== 4'b1000 || bram_we !== 1'b0 || rvalid !== 4'b0000) begin
      errors++; $display("FAIL rd_issue gnt/we/rvalid: got %b/%b/%b expected 1000/0/0000", gnt, bram_we, rvalid);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (rvalid !== 4'b1000 || rdata !== 36'h9_DEAD_BEEF) begin
      errors++; $display("FAIL rd_return rvalid/rdata: got %b/%h expected 1000/9deadbeef", rvalid, rdata);
    end
    checks++;
    if (bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== 10'h155) begin
      errors++; $display("FAIL idle_port en/we/addr: got %b/%b/%h expected 0/0/155", bram_en, bram_we, bram_addr);
    end
    // back-to-back reads from requesters 0 and 3
    drive(4'b1001, 4'b0000, 4'b1111);
    checks++;
    if (gnt !== 4'b0001 || rvalid !== 4'b0000) begin
      errors++; $display("FAIL b2b_first gnt/rvalid: got %b/%b expected 0001/0000", gnt, rvalid);
    end
    drive(4'b1000, 4'b0000, 4'b1111);
    checks++;
    if (gnt !== 4'b1000 || rvalid !== 4'b0001) begin
      errors++; $display("FAIL b2b_second gnt/rvalid: got %b/%b expected 1000/0001", gnt, rvalid);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (rvalid !== 4'b1000 || rdata !== 36'h9_DEAD_BEEF) begin
      errors++; $display("FAIL b2b_return rvalid/rdata: got %b/%h expected 1000/9deadbeef", rvalid, rdata);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    drive(4'b0100, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL drop_owner gnt: got %b expected 0100", gnt);
    end
    // owner 2 drops; ptr=3 so requester 0 wins and gets a fresh 4-grant burst
    for (int k = 0; k < 4; k++) begin
      drive(4'b0011, 4'b0000, 4'b0000);
      checks++;
      if (gnt !== 4'b0001) begin
        errors++; $display("FAIL drop_new_owner[%0d] gnt: got %b expected 0001", k, gnt);
      end
    end
    drive(4'b0011, 4'b0000, 4'b0000);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL drop_after_burst gnt: got %b expected 0010", gnt);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset_during_read();
    do_reset();
    drive(4'b0001, 4'b0000, 4'b0001);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL rstrd_gnt: got %b expected 0001", gnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || bram_en !== 1'b0) begin
      errors++; $display("FAIL rstrd_gnt_in_reset gnt/en: got %b/%b expected 0000/0", gnt, bram_en);
    end
    @(negedge clk); #1;
    checks++;
    if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin
      errors++; $display("FAIL rstrd_dropped rvalid/gnt: got %b/%b expected 0000/0000", rvalid, gnt);
    end
    @(negedge clk);
    rst = 1'b0; req = '0;
  endtask

  task automatic test_starvation();
    int         wt [NREQ];
    logic [3:0] nr;
    int         shown;
    shown = 0;
    for (int i = 0; i < NREQ; i++) wt[i] = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++)
        nr[i] = (req[i] && !gnt[i]) ? 1'b1 : ($urandom_range(0, 2) == 0);
      drive(nr, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      checks++;
      if (((gnt & (gnt - 4'd1)) !== 4'b0000) || ((gnt & ~req) !== 4'b0000) || (bram_en !== (|gnt))) begin
        errors++;
        if (shown < 10) $display("FAIL rand_gnt_legal: got gnt=%b en=%b with req=%b", gnt, bram_en, req);
        shown++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) wt[i]++;
        else wt[i] = 0;
        checks++;
        if (wt[i] > (NREQ-1)*MAX_BURST) begin
          errors++;
          if (shown < 10) $display("FAIL starvation[%0d]: got wait %0d expected <= %0d", i, wt[i], (NREQ-1)*MAX_BURST);
          shown++;
          wt[i] = 0;
        end
      end
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; req = '0; wr = '0; last = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || bram_en !== 1'b0 || rvalid !== 4'b0000 || dbg_st !== ARB_IDLE) begin
      errors++; $display("FAIL reset_state gnt/en/rvalid/st: got %b/%b/%b/%b expected 0000/0/0000/0",
                         gnt, bram_en, rvalid, dbg_st);
    end
    test_reset();
    test_burst_lock();
    test_early_release();
    test_write_read();
    test_owner_drop();
    test_reset_during_read();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
